// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Channel index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Rotating-priority picker: the first asserted request at or after base wins,
// wrapping from N-1 back to 0.
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter int N = 16,
  localparam int SW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] base,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  // Distance of every channel from base in search order.
  logic [SW:0] off [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_off
    localparam logic [SW:0] CH = (SW+1)'(gi);
    localparam logic [SW:0] NN = (SW+1)'(N);
    assign off[gi] = (CH >= {1'b0, base}) ? (CH - {1'b0, base})
                                          : (CH + NN - {1'b0, base});
  end

  logic [SW:0] best;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    best    = '1;
    for (int c = 0; c < N; c++) begin
      if (req[c] && (off[c] < best)) begin
        best    = off[c];
        gnt_vld = 1'b1;
        gnt_idx = SW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with fixed or round-robin selection feeding a
// single registered output slot that sustains one word per cycle.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 8,
  localparam int SW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready
);

  slot_state_e   state_q, state_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          rr_vld, fix_vld, gnt_vld;
  logic [SW-1:0] rr_idx, fix_idx, gnt_idx;
  logic [W-1:0]  gnt_data;
  logic          load, xfer_in;

  rr_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .base    (ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Compare sel against each legal index so an out-of-range sel matches nothing.
  always_comb begin
    fix_vld = 1'b0;
    fix_idx = '0;
    for (int c = 0; c < N; c++) begin
      if ((sel == SW'(c)) && in_valid[c]) begin
        fix_vld = 1'b1;
        fix_idx = SW'(c);
      end
    end
  end

  assign gnt_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
  assign gnt_idx = (mode == MODE_RR) ? rr_idx : fix_idx;
  assign load    = (state_q == SLOT_EMPTY) || out_ready;
  assign xfer_in = gnt_vld && load && !rst;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int c = 0; c < N; c++) begin
      if (gnt_idx == SW'(c)) begin
        gnt_data    = in_data[c*W +: W];
        in_ready[c] = xfer_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SLOT_EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (xfer_in) state_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !xfer_in) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    ptr_d      = ptr_q;
    if (xfer_in) begin
      out_data_d = gnt_data;
      out_ch_d   = gnt_idx;
      ptr_d      = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 16-channel instance checked through a
// scoreboard and a 5-channel instance for odd-N selection and wrap.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int NA = 16;
  localparam int WA = 8;
  localparam int NB = 5;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NA*WA-1:0] in_data_a;
  logic [NA-1:0]    in_valid_a, in_ready_a;
  logic             mode_a, out_valid_a, out_ready_a;
  logic [3:0]       sel_a, out_ch_a;
  logic [WA-1:0]    out_data_a;
  logic [WA-1:0]    dat_a [NA];

  logic [NB*WB-1:0] in_data_b;
  logic [NB-1:0]    in_valid_b, in_ready_b;
  logic             mode_b, out_valid_b, out_ready_b;
  logic [2:0]       sel_b, out_ch_b;
  logic [WB-1:0]    out_data_b;

  stream_mux_rr #(.N(NA), .W(WA)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .mode(mode_a), .sel(sel_a), .out_data(out_data_a),
    .out_ch(out_ch_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  stream_mux_rr #(.N(NB), .W(WB)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .mode(mode_b), .sel(sel_b), .out_data(out_data_b),
    .out_ch(out_ch_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  always_comb begin
    in_data_a = '0;
    for (int c = 0; c < NA; c++) in_data_a[c*WA +: WA] = dat_a[c];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] sb [$];
  int bseq [3] = '{3, 4, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int c);
    sb.push_back({4'(c), dat_a[c]});
  endtask

  task automatic pop_a(input string tag);
    logic [11:0] e;
    chk({tag, ".vld"}, 32'(out_valid_a), 32'd1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s.sb: observed ch %0d data %h, expected no output (queue empty)",
             tag, out_ch_a, out_data_a);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'({out_ch_a, out_data_a}), 32'(e));
    end
  endtask

  initial begin
    rst         = 1'b1;
    mode_a      = MODE_RR;
    sel_a       = '0;
    in_valid_a  = '1;
    out_ready_a = 1'b1;
    for (int c = 0; c < NA; c++) dat_a[c] = {4'(c), ~4'(c)};
    mode_b      = MODE_FIXED;
    sel_b       = 3'd6;
    in_valid_b  = '1;
    out_ready_b = 1'b1;
    in_data_b   = 20'h97531;
    tick();
    tick();

    // Reset state
    chk("rst.in_ready_a", 32'(in_ready_a), 32'd0);
    chk("rst.out_valid_a", 32'(out_valid_a), 32'd0);
    chk("rst.out_data_a", 32'(out_data_a), 32'd0);
    chk("rst.out_ch_a", 32'(out_ch_a), 32'd0);
    chk("rst.in_ready_b", 32'(in_ready_b), 32'd0);
    chk("rst.out_valid_b", 32'(out_valid_b), 32'd0);
    rst = 1'b0;

    // Round-robin fairness: 0..15 then 0, one word per cycle
    for (int k = 0; k <= NA; k++) begin
      #1 chk("rr.in_ready", 32'(in_ready_a), 32'(1) << (k % NA));
      push_a(k % NA);
      tick();
      pop_a("rr.out");
    end

    // Sparse requests after a grant to 0: 15 then wrap to 0
    in_valid_a = 16'h8001;
    #1 chk("sparse.in_ready15", 32'(in_ready_a), 32'h8000);
    push_a(15);
    tick();
    pop_a("sparse.out15");
    #1 chk("sparse.in_ready0", 32'(in_ready_a), 32'h0001);
    push_a(0);
    tick();
    pop_a("sparse.out0");

    // Drain: slot empties, data and channel hold
    in_valid_a = '0;
    #1 chk("drain.in_ready", 32'(in_ready_a), 32'd0);
    tick();
    chk("drain.out_valid", 32'(out_valid_a), 32'd0);
    chk("drain.hold", 32'({out_ch_a, out_data_a}), 32'h00F);

    // Odd N with sel beyond the last channel never grants
    chk("b.sel6.in_ready", 32'(in_ready_b), 32'd0);
    chk("b.sel6.out_valid", 32'(out_valid_b), 32'd0);

    // Fixed mode on channel 5
    mode_a     = MODE_FIXED;
    sel_a      = 4'd5;
    dat_a[5]   = 8'hA5;
    in_valid_a = '1;
    #1 chk("fix.in_ready", 32'(in_ready_a), 32'h0020);
    push_a(5);
    tick();
    pop_a("fix.out");

    // Backpressure: slot frozen, nothing accepted
    out_ready_a = 1'b0;
    dat_a[5]    = 8'h5A;
    repeat (3) begin
      #1 chk("bp.in_ready", 32'(in_ready_a), 32'd0);
      tick();
      chk("bp.hold", 32'({out_valid_a, out_ch_a, out_data_a}), 32'h15A5);
    end
    out_ready_a = 1'b1;
    #1 chk("bp.release.in_ready", 32'(in_ready_a), 32'h0020);
    push_a(5);
    tick();
    pop_a("bp.release.out");

    // Mode change applies to this cycle's grant; pointer sits at 6
    mode_a = MODE_RR;
    #1 chk("modesw.in_ready", 32'(in_ready_a), 32'h0040);
    push_a(6);
    tick();
    pop_a("modesw.out");

    // Fixed select of an idle channel grants nothing
    mode_a     = MODE_FIXED;
    sel_a      = 4'd3;
    in_valid_a = 16'hFFF7;
    #1 chk("fixidle.in_ready", 32'(in_ready_a), 32'd0);
    tick();
    chk("fixidle.out_valid", 32'(out_valid_a), 32'd0);

    // Odd N: legal fixed select, then round-robin wrap 3,4,0
    sel_b = 3'd2;
    #1 chk("b.fix.in_ready", 32'(in_ready_b), 32'h04);
    tick();
    chk("b.fix.out", 32'({out_valid_b, out_ch_b, out_data_b}), 32'hA5);
    mode_b = MODE_RR;
    for (int k = 0; k < 3; k++) begin
      #1 chk("b.rr.in_ready", 32'(in_ready_b), 32'(1) << bseq[k]);
      tick();
      chk("b.rr.out", 32'({out_valid_b, out_ch_b, out_data_b}),
          32'({1'b1, 3'(bseq[k]), 4'(2 * bseq[k] + 1)}));
    end

    // Mid-stream reset discards both slots and the pointers
    mode_a     = MODE_RR;
    in_valid_a = '1;
    #1 chk("pre.in_ready", 32'(in_ready_a), 32'h0080);
    push_a(7);
    tick();
    pop_a("pre.out");
    rst = 1'b1;
    #1 chk("midrst.in_ready_a", 32'(in_ready_a), 32'd0);
    chk("midrst.in_ready_b", 32'(in_ready_b), 32'd0);
    tick();
    chk("midrst.a", 32'({out_valid_a, out_ch_a, out_data_a}), 32'd0);
    chk("midrst.b", 32'({out_valid_b, out_ch_b, out_data_b}), 32'd0);
    sb.delete();
    rst = 1'b0;
    #1 chk("post.in_ready", 32'(in_ready_a), 32'h0001);
    push_a(0);
    tick();
    pop_a("post.out");

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
